// File: rtl/ring_rr_arbiter.sv
// Ring round-robin arbiter with a rotating one-hot priority pointer and a
// hold limit that forces re-arbitration after MAX_HOLD consecutive grant cycles.
module ring_rr_arbiter #(
   parameter int unsigned N        = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [N-1:0]         ptr,
   output logic                 timeout
);

   localparam int unsigned IW = $clog2(N);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic          grant_valid_q, grant_valid_d;
   logic [IW-1:0] grant_id_q, grant_id_d;
   logic [N-1:0]  ptr_q, ptr_d;
   logic [7:0]    hold_q, hold_d;
   logic          timeout_q, timeout_d;

   int unsigned   ptr_idx;
   logic [IW-1:0] win_id;
   logic          win_found;
   logic [N-1:0]  win_oh;
   logic          owner_req;

   always_comb begin
      ptr_idx = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (ptr_q[k]) ptr_idx = k;
      end
   end

   // Circular search starting at the pointer bit; first hit wins.
   always_comb begin
      int unsigned idx;
      win_id    = '0;
      win_found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (ptr_idx + k) % N;
         if (!win_found && req[idx[IW-1:0]]) begin
            win_found = 1'b1;
            win_id    = idx[IW-1:0];
         end
      end
   end

   assign win_oh    = {{(N-1){1'b0}}, 1'b1} << win_id;
   assign owner_req = |(req & grant_q);

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      ptr_d         = ptr_q;
      hold_d        = hold_q;
      timeout_d     = 1'b0;
      if (state_q == IDLE || !owner_req) begin
         // Idle arbitration and release share one path; release wins over timeout.
         if (en && win_found) begin
            state_d       = BUSY;
            grant_d       = win_oh;
            grant_valid_d = 1'b1;
            grant_id_d    = win_id;
            ptr_d         = {win_oh[N-2:0], win_oh[N-1]};
            hold_d        = 8'd1;
         end else begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            hold_d        = '0;
         end
      end else if (hold_q == 8'(MAX_HOLD)) begin
         timeout_d = 1'b1;
         hold_d    = 8'd1;
         if (en) begin
            grant_d    = win_oh;
            grant_id_d = win_id;
            ptr_d      = {win_oh[N-2:0], win_oh[N-1]};
         end
      end else begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         ptr_q         <= {{(N-1){1'b0}}, 1'b1};
         hold_q        <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         ptr_q         <= ptr_d;
         hold_q        <= hold_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign ptr         = ptr_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed and randomized checks of ring_rr_arbiter against a behavioural
// model tracking owner index, pointer index and hold count as integers.
module tb_ring_rr_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] req = '0;
   logic [7:0] grant;
   logic       grant_valid;
   logic [2:0] grant_id;
   logic [7:0] ptr;
   logic       timeout;

   ring_rr_arbiter #(.N(8), .MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req),
      .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
      .ptr(ptr), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   bit m_busy = 0;
   int m_own  = 0;
   int m_pidx = 0;
   int m_hold = 0;
   bit m_to   = 0;
   bit prev_to = 0;

   function automatic int pick(logic [7:0] q, int start);
      for (int k = 0; k < 8; k++)
         if (q[(start + k) % 8]) return (start + k) % 8;
      return -1;
   endfunction

   task automatic grant_to(logic [7:0] q);
      m_own  = pick(q, m_pidx);
      m_pidx = (m_own + 1) % 8;
      m_hold = 1;
      m_busy = 1;
   endtask

   task automatic model(bit r, bit e, logic [7:0] q);
      m_to = 0;
      if (r) begin
         m_busy = 0; m_own = 0; m_pidx = 0; m_hold = 0;
      end else if (!m_busy || !q[m_own]) begin
         if (e && q != 0) grant_to(q);
         else begin m_busy = 0; m_own = 0; m_hold = 0; end
      end else if (m_hold == MAXH) begin
         m_to = 1;
         if (e) grant_to(q);
         else m_hold = 1;
      end else begin
         m_hold++;
      end
   endtask

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(bit r, bit e, logic [7:0] q);
      logic [7:0] eg;
      rst = r; en = e; req = q;
      @(posedge clk);
      model(r, e, q);
      #1;
      eg = m_busy ? (8'h01 << m_own) : 8'h00;
      chk("grant", grant, eg);
      chk("grant_valid", {7'd0, grant_valid}, {7'd0, m_busy});
      chk("grant_id", {5'd0, grant_id}, m_busy ? 8'(m_own) : 8'd0);
      chk("ptr", ptr, 8'h01 << m_pidx);
      chk("timeout", {7'd0, timeout}, {7'd0, m_to});
      chk("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
      chk("id_match", grant_valid ? (8'h01 << grant_id) : 8'h00, grant);
      chk("timeout_twice", {7'd0, prev_to & timeout}, 8'd0);
      prev_to = timeout;
   endtask

   initial begin
      logic [7:0] rq;
      bit         re;
      // Reset then single requester held through a timeout
      cycle(1, 0, 8'h00);
      chk("reset_ptr", ptr, 8'h01);
      chk("reset_grant", grant, 8'h00);
      cycle(0, 1, 8'h01);
      chk("first_grant", grant, 8'h01);
      chk("first_ptr", ptr, 8'h02);
      for (int i = 0; i < 6; i++) cycle(0, 1, 8'h01);

      // Pointer at bit 6, wraparound win then release handover
      cycle(1, 0, 8'h00);
      cycle(0, 1, 8'h20);
      cycle(0, 1, 8'h00);
      chk("ptr_40", ptr, 8'h40);
      cycle(0, 1, 8'h81);
      chk("wrap_grant", grant, 8'h80);
      chk("wrap_ptr", ptr, 8'h01);
      cycle(0, 1, 8'h01);
      chk("handover", grant, 8'h01);

      // All requesting: full rotation with timeout handovers
      cycle(1, 0, 8'h00);
      for (int i = 0; i < 40; i++) cycle(0, 1, 8'hFF);

      // Release with en low, then fresh grant
      cycle(1, 0, 8'h00);
      cycle(0, 1, 8'h04);
      cycle(0, 0, 8'h04);
      cycle(0, 0, 8'h00);
      chk("idle_en0", grant, 8'h00);
      cycle(0, 1, 8'h10);
      chk("regrant", grant, 8'h10);

      // Timeout with en low keeps the owner
      for (int i = 0; i < 6; i++) cycle(0, 0, 8'h1F);

      // Reset mid-grant
      cycle(1, 0, 8'h00);
      cycle(0, 1, 8'h08);
      cycle(1, 1, 8'hFF);
      chk("rst_drop", grant, 8'h00);
      cycle(0, 1, 8'hFF);
      chk("post_rst", grant, 8'h01);

      // Randomized traffic
      rq = 8'h00;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) rq = 8'($urandom);
         if ($urandom_range(7) == 0) rq = rq & ~grant;
         re = ($urandom_range(59) == 0);
         cycle(re, $urandom_range(4) != 0, rq);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
